mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the IF instruction fetch and the data-memory accesses (load read, WB-stage store write).
- Sits between the pipeline's fetch/decode and execute/writeback stages and the memory macro.
- Sequences one transaction at a time through a request/ready handshake.
- Returns fetch data with a valid strobe, load data with a valid strobe, and a data-side stall to the pipeline.

Parameters:
- STARVE_LIMIT, 4: consecutive data grants allowed while a fetch is waiting. Used only with ARB_STARVE_GUARD_EN.
- RESET, 32'h0000_0000: value loaded into inst_rdata_q at reset.

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-low reset
- inst_req  in  1  fetch request; held with inst_addr until inst_valid
- inst_addr  in  32  fetch byte address
- inst_valid  out  1  one-cycle pulse: inst_rdata carries the fetched word
- inst_rdata  out  32  registered fetch data; held between completions
- dmem_read_ready  in  1  load request; held with dmem_read_address until dmem_read_valid
- dmem_read_address  in  32  load byte address
- dmem_write_ready  in  1  store request; held until dmem_write_done
- dmem_write_address  in  32  store byte address
- dmem_write_data  in  32  store data
- dmem_write_byte  in  4  store byte enables
- dmem_read_valid  out  1  one-cycle pulse: dmem_read_data is valid
- dmem_read_data  out  32  registered load data
- dmem_write_done  out  1  one-cycle pulse: store committed
- dmem_stall  out  1  combinational; high while any data request is pending and not completing this cycle
- mem_req  out  1  memory request; held until mem_ready
- mem_we  out  1  1 = write
- mem_addr  out  32  memory byte address
- mem_wdata  out  32  write data
- mem_wstrb  out  4  write byte strobes; 0 on reads
- mem_ready  in  1  memory completes the current request this cycle
- mem_rdata  in  32  read data, valid with mem_ready

Behaviour:
- Reset is synchronous: on a clk edge with reset=0:
  - state <= IDLE
  - all outputs 0, except inst_rdata <= RESET
  - starvation counter <= 0
- Reset mid-transaction:
  - mem_req drops on that edge and any later mem_ready is ignored.
  - The requester must re-request; the memory must tolerate an abandoned request.
- FSM states: IDLE, GNT_WR, GNT_RD, GNT_IF.
- Arbitration is evaluated in IDLE only. Priority: store > load > fetch.
  - A store is issued before a simultaneous load because the WB store is older; this preserves store-then-load ordering to the same address.
- IDLE -> GNT_x on the edge where the winning request is high. On that same edge:
  - mem_req <= 1
  - mem_addr, mem_we, mem_wdata, mem_wstrb are registered from the winning requester.
- GNT_x holds all mem_* outputs stable until mem_ready=1. On the mem_ready edge:
  - mem_req <= 0; state <= IDLE
  - GNT_RD: dmem_read_data <= mem_rdata; dmem_read_valid <= 1
  - GNT_IF: inst_rdata <= mem_rdata; inst_valid <= 1
  - GNT_WR: dmem_write_done <= 1
- Done/valid pulses last exactly one cycle.
- Minimum latency:
  - request seen at edge N, mem_req high after N
  - mem_ready=1 in the first grant cycle gives its edge N+1 and a valid/done pulse after N+1
  - IDLE is re-entered after N+1, so back-to-back transactions cost 2 cycles each.
- A request deasserted while in IDLE is never issued. A request deasserted during its grant is still completed, and its pulse is still issued.
- dmem_stall = (dmem_read_ready | dmem_write_ready) & ~(completion pulse for that side being produced this cycle).
  - With both store and load pending, dmem_stall stays high through the store completion and clears in the load's valid cycle.
- Address alignment is not checked; the misaligned-fetch exception is raised upstream.
- Fetch is starved indefinitely while data requests are continuously present, unless the optional feature is compiled in.

Optional Feature:
- Macro: ARB_STARVE_GUARD_EN.
- When defined:
  - A 3-bit saturating counter increments on each data grant issued while inst_req=1.
  - It clears on any fetch grant.
  - When the counter equals STARVE_LIMIT, fetch wins the next IDLE arbitration regardless of pending data.
- When undefined: no counter exists; strict store > load > fetch priority applies.

Decomposition:
- Package mem_arb_pkg:
  - state encoding: IDLE=2'd0, GNT_WR=2'd1, GNT_RD=2'd2, GNT_IF=2'd3
  - requester-select constants
  - STRB_NONE=4'b0000
- Sub-module arb_starve_cnt: the starvation counter and force-fetch flag, instantiated only under ARB_STARVE_GUARD_EN.

Test Plan:
- Reset and single fetch:
  - Stimulus: hold reset=0 for 2 cycles with inst_req=1, then release; inst_addr=32'h0000_0004, memory returns 32'h0000_0013 with mem_ready in the first grant cycle.
  - Required: after reset, inst_rdata=RESET with all pulses low; the one-cycle inst_valid pulse comes 2 cycles after the request edge, with inst_rdata=32'h0000_0013.
- Collision:
  - Stimulus: store, load and fetch all asserted in the same cycle.
  - Required: mem_we=1 grant first, then the load, then the fetch; dmem_stall is high until the dmem_read_valid cycle.
- Store-then-load:
  - Stimulus: store 32'hDEAD_BEEF with byte enable 4'b1111 to 32'h100, plus a simultaneous load from 32'h100.
  - Required: dmem_read_data=32'hDEAD_BEEF.
- Wait states:
  - Stimulus: mem_ready held low for 5 cycles during a load.
  - Required: mem_addr and mem_req are stable throughout; the single dmem_read_valid pulse follows the mem_ready edge.
- Reset mid-grant:
  - Stimulus: reset=0 while in GNT_RD, then a late mem_ready after reset is released.
  - Required: mem_req=0 after the reset edge; no dmem_read_valid is produced.
- With ARB_STARVE_GUARD_EN and STARVE_LIMIT=4:
  - Stimulus: continuous loads plus inst_req=1.
  - Required: a fetch grant occurs after exactly 4 load grants. Without the macro, no fetch grant occurs.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// mem_arb_pkg - shared types for the unified-memory port arbiter:
// FSM state encoding, requester-select codes, strobe constant and the
// fixed-priority pick function (store > load > fetch, optional fetch force).
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GNT_WR = 2'd1,
        GNT_RD = 2'd2,
        GNT_IF = 2'd3
    } arb_state_e;

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_WR   = 2'd1,
        SEL_RD   = 2'd2,
        SEL_IF   = 2'd3
    } req_sel_e;

    localparam logic [3:0] STRB_NONE = 4'b0000;

    // The WB store is older than the load, so it goes first; this keeps
    // store-then-load ordering to the same address. force_if lets a
    // starved fetch jump the queue.
    function automatic req_sel_e arb_pick(input logic wr_req,
                                          input logic rd_req,
                                          input logic if_req,
                                          input logic force_if);
        req_sel_e sel;
        if (force_if && if_req) begin
            sel = SEL_IF;
        end else if (wr_req) begin
            sel = SEL_WR;
        end else if (rd_req) begin
            sel = SEL_RD;
        end else if (if_req) begin
            sel = SEL_IF;
        end else begin
            sel = SEL_NONE;
        end
        return sel;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if - pipeline request side and memory side of the
// arbiter. slave = arbiter view, master = pipeline + memory environment.
interface mem_port_arbiter_if;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_valid;
    logic [31:0] inst_rdata;
    logic        dmem_read_ready;
    logic [31:0] dmem_read_address;
    logic        dmem_write_ready;
    logic [31:0] dmem_write_address;
    logic [31:0] dmem_write_data;
    logic [3:0]  dmem_write_byte;
    logic        dmem_read_valid;
    logic [31:0] dmem_read_data;
    logic        dmem_write_done;
    logic        dmem_stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport slave (
        input  inst_req, inst_addr,
        input  dmem_read_ready, dmem_read_address,
        input  dmem_write_ready, dmem_write_address, dmem_write_data, dmem_write_byte,
        input  mem_ready, mem_rdata,
        output inst_valid, inst_rdata,
        output dmem_read_valid, dmem_read_data, dmem_write_done, dmem_stall,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
    );

    modport master (
        output inst_req, inst_addr,
        output dmem_read_ready, dmem_read_address,
        output dmem_write_ready, dmem_write_address, dmem_write_data, dmem_write_byte,
        output mem_ready, mem_rdata,
        input  inst_valid, inst_rdata,
        input  dmem_read_valid, dmem_read_data, dmem_write_done, dmem_stall,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
    );
endinterface

// File: rtl/mem_port_arbiter_starve_cnt.sv
// arb_starve_cnt - fetch starvation counter for the memory port arbiter.
// Only exists in builds with ARB_STARVE_GUARD_EN defined.
`ifdef ARB_STARVE_GUARD_EN
module arb_starve_cnt #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_data_grant,
    input  logic i_fetch_grant,
    input  logic i_inst_req,
    output logic o_force_if
);
    localparam logic [2:0] LIMIT_W = 3'(STARVE_LIMIT);

    logic [2:0] r_cnt;

    // Count data grants that overtook a waiting fetch; saturate at 7, clear on fetch grant.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt <= 3'd0;
        end else if (i_fetch_grant) begin
            r_cnt <= 3'd0;
        end else if (i_data_grant && i_inst_req && (r_cnt != 3'd7)) begin
            r_cnt <= r_cnt + 3'd1;
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_force_if = (r_cnt == LIMIT_W);
endmodule
`endif

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter - shares one single-ported memory between instruction
// fetch, loads and WB stores, one transaction at a time.
// Optional macro: ARB_STARVE_GUARD_EN (forces a fetch after STARVE_LIMIT
// data grants that overtook it).
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter logic [31:0] RESET        = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    mem_port_arbiter_if.slave bus
);
    arb_state_e  r_state;
    arb_state_e  w_next_state;
    req_sel_e    w_sel;
    logic        w_force_if;
    logic        w_issue;
    logic        w_complete;
    logic        w_wr_done;
    logic        w_rd_done;
    logic        w_if_done;
    logic        w_issue_we;
    logic [31:0] w_issue_addr;
    logic [31:0] w_issue_wdata;
    logic [3:0]  w_issue_strb;

    logic        r_mem_req;
    logic        r_mem_we;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic [3:0]  r_mem_wstrb;
    logic        r_inst_valid;
    logic [31:0] r_inst_rdata;
    logic        r_rd_valid;
    logic [31:0] r_rd_data;
    logic        r_wr_done;

`ifdef ARB_STARVE_GUARD_EN
    arb_starve_cnt #(.STARVE_LIMIT(STARVE_LIMIT)) u_starve_cnt (
        .clk           (clk),
        .reset         (reset),
        .i_data_grant  (w_issue && (w_sel != SEL_IF)),
        .i_fetch_grant (w_issue && (w_sel == SEL_IF)),
        .i_inst_req    (bus.inst_req),
        .o_force_if    (w_force_if)
    );
`else
    // No guard: fetch never jumps the queue; the limit stays referenced so
    // both builds share one parameter list.
    assign w_force_if = 1'b0 & (STARVE_LIMIT != 0);
`endif

    assign w_sel = arb_pick(bus.dmem_write_ready, bus.dmem_read_ready, bus.inst_req, w_force_if);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next state: arbitrate only in IDLE, return to IDLE on mem_ready.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                case (w_sel)
                    SEL_WR:  w_next_state = GNT_WR;
                    SEL_RD:  w_next_state = GNT_RD;
                    SEL_IF:  w_next_state = GNT_IF;
                    default: w_next_state = IDLE;
                endcase
            end
            GNT_WR, GNT_RD, GNT_IF: begin
                if (bus.mem_ready) begin
                    w_next_state = IDLE;
                end else begin
                    w_next_state = r_state;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // FSM outputs: issue/complete strobes and the winning requester's fields.
    always_comb begin
        w_issue       = 1'b0;
        w_complete    = 1'b0;
        w_wr_done     = 1'b0;
        w_rd_done     = 1'b0;
        w_if_done     = 1'b0;
        w_issue_we    = 1'b0;
        w_issue_addr  = 32'h0000_0000;
        w_issue_wdata = 32'h0000_0000;
        w_issue_strb  = STRB_NONE;
        if (r_state == IDLE) begin
            w_issue = (w_sel != SEL_NONE);
        end else begin
            w_complete = bus.mem_ready;
        end
        case (r_state)
            GNT_WR:  w_wr_done = bus.mem_ready;
            GNT_RD:  w_rd_done = bus.mem_ready;
            GNT_IF:  w_if_done = bus.mem_ready;
            default: w_wr_done = 1'b0;
        endcase
        case (w_sel)
            SEL_WR: begin
                w_issue_we    = 1'b1;
                w_issue_addr  = bus.dmem_write_address;
                w_issue_wdata = bus.dmem_write_data;
                w_issue_strb  = bus.dmem_write_byte;
            end
            SEL_RD:  w_issue_addr = bus.dmem_read_address;
            SEL_IF:  w_issue_addr = bus.inst_addr;
            default: w_issue_addr = 32'h0000_0000;
        endcase
    end

    // Registered memory request, return data and one-cycle completion pulses.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= 32'h0000_0000;
            r_mem_wdata  <= 32'h0000_0000;
            r_mem_wstrb  <= STRB_NONE;
            r_inst_valid <= 1'b0;
            r_inst_rdata <= RESET;
            r_rd_valid   <= 1'b0;
            r_rd_data    <= 32'h0000_0000;
            r_wr_done    <= 1'b0;
        end else begin
            r_inst_valid <= w_if_done;
            r_rd_valid   <= w_rd_done;
            r_wr_done    <= w_wr_done;
            if (w_issue) begin
                r_mem_req   <= 1'b1;
                r_mem_we    <= w_issue_we;
                r_mem_addr  <= w_issue_addr;
                r_mem_wdata <= w_issue_wdata;
                r_mem_wstrb <= w_issue_strb;
            end else if (w_complete) begin
                r_mem_req   <= 1'b0;
            end
            if (w_rd_done) begin
                r_rd_data <= bus.mem_rdata;
            end
            if (w_if_done) begin
                r_inst_rdata <= bus.mem_rdata;
            end
        end
    end

    assign bus.mem_req         = r_mem_req;
    assign bus.mem_we          = r_mem_we;
    assign bus.mem_addr        = r_mem_addr;
    assign bus.mem_wdata       = r_mem_wdata;
    assign bus.mem_wstrb       = r_mem_wstrb;
    assign bus.inst_valid      = r_inst_valid;
    assign bus.inst_rdata      = r_inst_rdata;
    assign bus.dmem_read_valid = r_rd_valid;
    assign bus.dmem_read_data  = r_rd_data;
    assign bus.dmem_write_done = r_wr_done;
    // A side stalls while it requests and its completion pulse is not out this cycle.
    assign bus.dmem_stall = (bus.dmem_read_ready  & ~r_rd_valid) |
                            (bus.dmem_write_ready & ~r_wr_done);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter - randomized bench with a transaction-level model of
// the arbiter (idle/busy + winner) and a byte-addressed memory model.
module tb_mem_port_arbiter;
    localparam logic [31:0] RESET_VAL = 32'hA5A5_0004;
    localparam int          LIMIT     = 4;
    localparam int          K_WR = 1, K_RD = 2, K_IF = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_port_arbiter_if bus();
    mem_port_arbiter #(.STARVE_LIMIT(LIMIT), .RESET(RESET_VAL)) dut (
        .clk(clk), .reset(reset), .bus(bus));

    int errors = 0;
    int checks = 0;

    logic [31:0] mem_model [logic [29:0]];
    bit          busy = 1'b0;
    int          winner = 0;
    bit          g_we;
    logic [31:0] g_addr, g_wdata;
    logic [3:0]  g_strb;
    int          wait_left = 0;
    int          wait_mode = 0;
    bit          idle_noise = 1'b0;
    bit          prev_req = 1'b0;
    bit          obs_we[$];
    logic [31:0] obs_addr[$];
    int          rd_pulses = 0, if_pulses = 0, wr_pulses = 0;
    logic [31:0] last_rd_data, last_if_data;
`ifdef ARB_STARVE_GUARD_EN
    int          starve_cnt = 0;
`endif

    function automatic logic [31:0] mread(input logic [31:0] a);
        logic [29:0] k;
        k = a[31:2];
        if (mem_model.exists(k)) return mem_model[k];
        return {a[15:0], ~a[15:0]};
    endfunction

    function automatic void mwrite(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] w;
        w = mread(a);
        for (int b = 0; b < 4; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
        mem_model[a[31:2]] = w;
    endfunction

    // Which requester the rules say wins an IDLE arbitration.
    function automatic int pick(input bit w, input bit r, input bit f);
`ifdef ARB_STARVE_GUARD_EN
        if (f && starve_cnt == LIMIT) return K_IF;
`endif
        if (w) return K_WR;
        if (r) return K_RD;
        if (f) return K_IF;
        return 0;
    endfunction

    // One clock: predict, advance, compare, then act as requesters and memory.
    task automatic step();
        bit s_wr, s_rd, s_if, s_rdy;
        logic [2:0]  exp_pulse;
        logic [31:0] exp_rdata;
        bit          exp_stall;
        s_wr = bus.dmem_write_ready; s_rd = bus.dmem_read_ready;
        s_if = bus.inst_req;         s_rdy = bus.mem_ready;
        exp_pulse = 3'b000;
        exp_rdata = bus.mem_rdata;
        if (!busy) begin
            if (s_wr || s_rd || s_if) begin
                winner = pick(s_wr, s_rd, s_if);
                busy = 1'b1;
                g_we = (winner == K_WR);
                g_wdata = 32'h0; g_strb = 4'h0;
                if (winner == K_WR) begin
                    g_addr = bus.dmem_write_address; g_wdata = bus.dmem_write_data;
                    g_strb = bus.dmem_write_byte;
                end else if (winner == K_RD) g_addr = bus.dmem_read_address;
                else g_addr = bus.inst_addr;
`ifdef ARB_STARVE_GUARD_EN
                if (winner == K_IF) starve_cnt = 0;
                else if (s_if && starve_cnt < 7) starve_cnt++;
`endif
                wait_left = (wait_mode >= 0) ? wait_mode : int'($urandom_range(0, 3));
            end
        end else if (s_rdy) begin
            busy = 1'b0;
            if (winner == K_WR) begin exp_pulse = 3'b100; mwrite(g_addr, g_wdata, g_strb); end
            else if (winner == K_RD) exp_pulse = 3'b010;
            else exp_pulse = 3'b001;
        end
        @(posedge clk); #1;
        checks++;
        if (bus.mem_req !== busy) begin
            errors++; $display("FAIL mem_req: got %0b want %0b", bus.mem_req, busy);
        end
        if (busy) begin
            checks++;
            if ({bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb} !== {g_we, g_addr, g_wdata, g_strb}) begin
                errors++;
                $display("FAIL grant_fields: got we=%0b addr=%h wdata=%h strb=%h want we=%0b addr=%h wdata=%h strb=%h",
                         bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb, g_we, g_addr, g_wdata, g_strb);
            end
        end
        checks++;
        if ({bus.dmem_write_done, bus.dmem_read_valid, bus.inst_valid} !== exp_pulse) begin
            errors++;
            $display("FAIL pulses(wr,rd,if): got %b want %b", {bus.dmem_write_done, bus.dmem_read_valid, bus.inst_valid}, exp_pulse);
        end
        if (exp_pulse == 3'b010) begin
            checks++;
            if (bus.dmem_read_data !== exp_rdata) begin
                errors++; $display("FAIL load_data: got %h want %h", bus.dmem_read_data, exp_rdata);
            end
        end
        if (exp_pulse == 3'b001) begin
            checks++;
            if (bus.inst_rdata !== exp_rdata) begin
                errors++; $display("FAIL fetch_data: got %h want %h", bus.inst_rdata, exp_rdata);
            end
        end
        exp_stall = (s_wr && !exp_pulse[2]) || (s_rd && !exp_pulse[1]);
        checks++;
        if (bus.dmem_stall !== exp_stall) begin
            errors++; $display("FAIL dmem_stall: got %0b want %0b", bus.dmem_stall, exp_stall);
        end
        if (bus.mem_req && !prev_req) begin obs_we.push_back(bus.mem_we); obs_addr.push_back(bus.mem_addr); end
        prev_req = bus.mem_req;
        if (bus.dmem_read_valid) begin rd_pulses++; last_rd_data = bus.dmem_read_data; end
        if (bus.inst_valid)      begin if_pulses++; last_if_data = bus.inst_rdata; end
        if (bus.dmem_write_done) wr_pulses++;
        if (exp_pulse[2]) bus.dmem_write_ready = 1'b0;
        if (exp_pulse[1]) bus.dmem_read_ready  = 1'b0;
        if (exp_pulse[0]) bus.inst_req         = 1'b0;
        if (busy) begin
            if (wait_left == 0) begin bus.mem_ready = 1'b1; bus.mem_rdata = mread(g_addr); end
            else begin bus.mem_ready = 1'b0; bus.mem_rdata = $urandom; wait_left--; end
        end else begin
            bus.mem_ready = idle_noise ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.mem_rdata = $urandom;
        end
    endtask

    task automatic apply_reset(input int n);
        reset = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb,
                 bus.inst_valid, bus.dmem_read_valid, bus.dmem_write_done, bus.dmem_read_data} !== 105'd0) begin
                errors++;
                $display("FAIL reset_outputs: got req=%0b we=%0b addr=%h pulses=%b rdata=%h want all zero",
                         bus.mem_req, bus.mem_we, bus.mem_addr,
                         {bus.dmem_write_done, bus.dmem_read_valid, bus.inst_valid}, bus.dmem_read_data);
            end
            checks++;
            if (bus.inst_rdata !== RESET_VAL) begin
                errors++; $display("FAIL reset_inst_rdata: got %h want %h", bus.inst_rdata, RESET_VAL);
            end
        end
        reset = 1'b1;
        busy = 1'b0; prev_req = 1'b0; bus.mem_ready = 1'b0;
`ifdef ARB_STARVE_GUARD_EN
        starve_cnt = 0;
`endif
    endtask

    task automatic run_until_idle(input int budget);
        int n = 0;
        while ((busy || bus.inst_req || bus.dmem_read_ready || bus.dmem_write_ready) && n < budget) begin
            step(); n++;
        end
        checks++;
        if (busy || bus.inst_req || bus.dmem_read_ready || bus.dmem_write_ready) begin
            errors++; $display("FAIL drain_timeout: still busy after %0d cycles, want idle", budget);
        end
    endtask

    task automatic test_reset();
        int found = 0;
        bus.inst_req = 1'b1; bus.inst_addr = 32'h0000_0004;
        mem_model[30'd1] = 32'h0000_0013;
        wait_mode = 0;
        apply_reset(2);
        for (int n = 1; n <= 10; n++) begin
            step();
            if (bus.inst_valid) begin found = n; break; end
        end
        checks++;
        if (found != 2) begin errors++; $display("FAIL fetch_latency: got %0d want 2", found); end
        checks++;
        if (bus.inst_rdata !== 32'h0000_0013) begin
            errors++; $display("FAIL fetch_word: got %h want 00000013", bus.inst_rdata);
        end
        run_until_idle(10);
    endtask

    task automatic test_collision();
        obs_we.delete(); obs_addr.delete();
        bus.dmem_write_ready = 1'b1; bus.dmem_write_address = 32'h200;
        bus.dmem_write_data = $urandom; bus.dmem_write_byte = 4'b0101;
        bus.dmem_read_ready = 1'b1; bus.dmem_read_address = 32'h204;
        bus.inst_req = 1'b1; bus.inst_addr = 32'h208;
        wait_mode = 0;
        run_until_idle(20);
        checks++;
        if (obs_addr.size() != 3) begin
            errors++; $display("FAIL collision_count: got %0d want 3", obs_addr.size());
        end else begin
            checks++;
            if ({obs_we[0], obs_addr[0], obs_we[1], obs_addr[1], obs_we[2], obs_addr[2]} !==
                {1'b1, 32'h200, 1'b0, 32'h204, 1'b0, 32'h208}) begin
                errors++;
                $display("FAIL collision_order: got %0b/%h %0b/%h %0b/%h want 1/200 0/204 0/208",
                         obs_we[0], obs_addr[0], obs_we[1], obs_addr[1], obs_we[2], obs_addr[2]);
            end
        end
    endtask

    task automatic test_store_then_load();
        mem_model[30'h40] = 32'h1111_1111;
        bus.dmem_write_ready = 1'b1; bus.dmem_write_address = 32'h100;
        bus.dmem_write_data = 32'hDEAD_BEEF; bus.dmem_write_byte = 4'b1111;
        bus.dmem_read_ready = 1'b1; bus.dmem_read_address = 32'h100;
        wait_mode = 0;
        run_until_idle(20);
        checks++;
        if (last_rd_data !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL store_then_load: got %h want deadbeef", last_rd_data);
        end
    endtask

    task automatic test_wait_states();
        int first = 0;
        int base = rd_pulses;
        bus.dmem_read_ready = 1'b1; bus.dmem_read_address = 32'h300;
        wait_mode = 5;
        for (int n = 1; n <= 12; n++) begin
            step();
            if (bus.dmem_read_valid && first == 0) first = n;
        end
        checks++;
        if (first != 7) begin errors++; $display("FAIL wait_valid_cycle: got %0d want 7", first); end
        checks++;
        if (rd_pulses - base != 1) begin
            errors++; $display("FAIL wait_valid_count: got %0d want 1", rd_pulses - base);
        end
        wait_mode = 0;
    endtask

    task automatic test_reset_mid_grant();
        int base = rd_pulses;
        bus.dmem_read_ready = 1'b1; bus.dmem_read_address = 32'h400;
        wait_mode = 10;
        step(); step();
        bus.dmem_read_ready = 1'b0;
        apply_reset(1);
        bus.mem_ready = 1'b1; idle_noise = 1'b1;
        for (int n = 0; n < 4; n++) step();
        idle_noise = 1'b0;
        checks++;
        if (rd_pulses != base) begin
            errors++; $display("FAIL abandoned_read_valid: got %0d pulses want 0", rd_pulses - base);
        end
        wait_mode = 0;
    endtask

    task automatic test_random();
        wait_mode = -1; idle_noise = 1'b1;
        for (int c = 0; c < 400; c++) begin
            if (!bus.dmem_write_ready && $urandom_range(0, 2) == 0) begin
                bus.dmem_write_ready = 1'b1;
                bus.dmem_write_address = 32'h1000 + 32'($urandom_range(0, 7)) * 32'd4;
                bus.dmem_write_data = $urandom; bus.dmem_write_byte = 4'($urandom_range(0, 15));
            end
            if (!bus.dmem_read_ready && $urandom_range(0, 2) == 0) begin
                bus.dmem_read_ready = 1'b1;
                bus.dmem_read_address = 32'h1000 + 32'($urandom_range(0, 7)) * 32'd4;
            end
            if (!bus.inst_req && $urandom_range(0, 2) == 0) begin
                bus.inst_req = 1'b1;
                bus.inst_addr = 32'h1000 + 32'($urandom_range(0, 7)) * 32'd4;
            end
            if ($urandom_range(0, 19) == 0) bus.dmem_read_ready = 1'b0;
            if ($urandom_range(0, 19) == 0) bus.inst_req = 1'b0;
            step();
        end
        idle_noise = 1'b0;
        run_until_idle(40);
        wait_mode = 0;
    endtask

    task automatic test_starvation();
        int loads = 0;
        int fetch_at = -1;
        int seen;
        apply_reset(1);
        obs_we.delete(); obs_addr.delete();
        bus.inst_req = 1'b1; bus.inst_addr = 32'h2000;
        wait_mode = 0;
        for (int n = 0; n < 30 && fetch_at < 0 && loads < 12; n++) begin
            if (!bus.dmem_read_ready) begin
                bus.dmem_read_ready = 1'b1;
                bus.dmem_read_address = 32'h3000 + 32'(n) * 32'd4;
            end
            seen = obs_addr.size();
            step();
            if (obs_addr.size() > seen) begin
                if (obs_addr[seen] == 32'h2000) fetch_at = loads;
                else loads++;
            end
        end
`ifdef ARB_STARVE_GUARD_EN
        checks++;
        if (fetch_at != LIMIT) begin
            errors++; $display("FAIL starve_guard: fetch after %0d loads want %0d", fetch_at, LIMIT);
        end
`else
        checks++;
        if (fetch_at != -1) begin
            errors++; $display("FAIL strict_priority: fetch granted after %0d loads want none", fetch_at);
        end
`endif
        bus.dmem_read_ready = 1'b0;
        run_until_idle(20);
    endtask

    initial begin
        reset = 1'b1;
        bus.inst_req = 1'b0; bus.inst_addr = 32'h0;
        bus.dmem_read_ready = 1'b0; bus.dmem_read_address = 32'h0;
        bus.dmem_write_ready = 1'b0; bus.dmem_write_address = 32'h0;
        bus.dmem_write_data = 32'h0; bus.dmem_write_byte = 4'h0;
        bus.mem_ready = 1'b0; bus.mem_rdata = 32'h0;
        test_reset();
        test_collision();
        test_store_then_load();
        test_wait_states();
        test_reset_mid_grant();
        test_random();
        test_starvation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
